// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard that tracks outstanding producers between issue and writeback.
module regfile_mp_sb #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter int BYPASS  = 1,
  parameter int DBG_IDX = 4,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [AW:0]         busy_cnt,
  output logic [XLEN-1:0]     dbg_data
);

  localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] iss_mask;
  logic [NREGS-1:0] drop_mask;
  logic [AW:0]      busy_cnt_reg;
  logic [AW:0]      busy_cnt_next;
  logic [AW:0]      dec_cnt;
  logic             inc_bit;

  // Issue is applied after write-clears so a same-cycle new producer keeps the bit set.
  always_comb begin
    clr_mask = '0;
    iss_mask = '0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i]) clr_mask[wr_addr[i*AW +: AW]] = 1'b1;
    end
    if (iss_en) iss_mask[iss_addr] = 1'b1;
    clr_mask[0] = 1'b0;
    iss_mask[0] = 1'b0;
    busy_next   = (busy_reg & ~clr_mask) | iss_mask;
  end

  // Counter moves by the bits that actually rise or fall this edge.
  always_comb begin
    drop_mask = busy_reg & clr_mask & ~iss_mask;
    inc_bit   = |(iss_mask & ~busy_reg);
    dec_cnt   = '0;
    for (int j = 1; j < NREGS; j++) begin
      dec_cnt = dec_cnt + {{AW{1'b0}}, drop_mask[j]};
    end
    busy_cnt_next = busy_cnt_reg + {{AW{1'b0}}, inc_bit} - dec_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_reg[r] <= '0;
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest index wins a collision.
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
          regs_reg[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
      end
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic            hit;
      logic [XLEN-1:0] byp;

      assign ra = rd_addr[gi*AW +: AW];

      always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int i = 0; i < NWR; i++) begin
          if ((BYPASS != 0) && wr_en[i] && (wr_addr[i*AW +: AW] == ra)) begin
            hit = 1'b1;
            byp = wr_data[i*XLEN +: XLEN];
          end
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = (ra == '0) ? '0 : (hit ? byp : regs_reg[ra]);
      assign rd_busy[gi]              = (ra != '0) && !hit && busy_reg[ra];
    end
  endgenerate

  assign busy_cnt = busy_cnt_reg;
  assign dbg_data = regs_reg[DBG_A];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a bypassing and a non-bypassing instance share stimulus
// and are checked every cycle against an array-based model plus literal expectations.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  logic [NRD*XLEN-1:0] rd_data_b1, rd_data_b0;
  logic [NRD-1:0]      rd_busy_b1, rd_busy_b0;
  logic [AW:0]         busy_cnt_b1, busy_cnt_b0;
  logic [XLEN-1:0]     dbg_data_b1, dbg_data_b0;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  always #5 clk = ~clk;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .DBG_IDX(4)) dut_b1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt_b1), .dbg_data(dbg_data_b1)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .DBG_IDX(4)) dut_b0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt_b0), .dbg_data(dbg_data_b0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model of the architectural state, updated from the rules at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i]) begin
          if (wr_addr[i*AW +: AW] != 0) m_regs[wr_addr[i*AW +: AW]] = wr_data[i*XLEN +: XLEN];
          m_busy[wr_addr[i*AW +: AW]] = 1'b0;
        end
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    if (byp)
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[i*AW +: AW] == a) v = wr_data[i*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (byp)
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[i*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [AW:0] exp_cnt();
    logic [AW:0] c = '0;
    for (int r = 1; r < NREGS; r++) c = c + (m_busy[r] ? 1 : 0);
    return c;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("m_rd_b1[%0d]", k), 64'(rd_data_b1[k*XLEN +: XLEN]), 64'(exp_rd(1'b1, rd_addr[k*AW +: AW])));
        chk($sformatf("m_rd_b0[%0d]", k), 64'(rd_data_b0[k*XLEN +: XLEN]), 64'(exp_rd(1'b0, rd_addr[k*AW +: AW])));
        chk($sformatf("m_busy_b1[%0d]", k), 64'(rd_busy_b1[k]), 64'(exp_busy(1'b1, rd_addr[k*AW +: AW])));
        chk($sformatf("m_busy_b0[%0d]", k), 64'(rd_busy_b0[k]), 64'(exp_busy(1'b0, rd_addr[k*AW +: AW])));
      end
      chk("m_cnt_b1", 64'(busy_cnt_b1), 64'(exp_cnt()));
      chk("m_cnt_b0", 64'(busy_cnt_b0), 64'(exp_cnt()));
      chk("m_dbg_b1", 64'(dbg_data_b1), 64'(m_regs[4]));
      chk("m_dbg_b0", 64'(dbg_data_b0), 64'(m_regs[4]));
    end
  end

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask
  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask
  task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1; wr_addr[p*AW +: AW] = a; wr_data[p*XLEN +: XLEN] = d;
  endtask
  task automatic iss(input logic [AW-1:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    idle(); rd2(5, 5); rst = 1'b1;
    nxt(); nxt();
    idle(); chk_en = 1'b1;

    // after reset
    mid();
    chk("rst_rd", 64'(rd_data_b1), 64'h0);
    chk("rst_busy", 64'(rd_busy_b1), 64'h0);
    chk("rst_cnt", 64'(busy_cnt_b1), 64'h0);
    chk("rst_dbg", 64'(dbg_data_b1), 64'h0);
    nxt();

    // write x5, read x5 on both ports
    idle(); rd2(5, 5); wr(0, 5, 32'hDEADBEEF);
    mid();
    chk("byp1_x5", 64'(rd_data_b1), 64'hDEADBEEF_DEADBEEF);
    chk("byp0_x5_same", 64'(rd_data_b0), 64'h0);
    nxt(); idle();
    mid();
    chk("byp0_x5_next", 64'(rd_data_b0), 64'hDEADBEEF_DEADBEEF);
    nxt();

    // x0 is hardwired zero
    idle(); rd2(0, 0); wr(0, 0, 32'h12345678); iss(0);
    mid();
    chk("x0_rd", 64'(rd_data_b1), 64'h0);
    chk("x0_busy", 64'(rd_busy_b1), 64'h0);
    nxt(); idle();
    mid();
    chk("x0_cnt", 64'(busy_cnt_b1), 64'h0);
    nxt();

    // port collision on x7
    idle(); rd2(7, 7); wr(0, 7, 32'h1); wr(1, 7, 32'h2);
    mid();
    chk("coll_byp", 64'(rd_data_b1[31:0]), 64'h2);
    nxt(); idle();
    mid();
    chk("coll_store", 64'(rd_data_b0[31:0]), 64'h2);
    nxt();

    // scoreboard on x3
    idle(); rd2(3, 3); iss(3);
    nxt(); idle();
    mid();
    chk("iss_busy", 64'(rd_busy_b1), 64'h3);
    chk("iss_cnt", 64'(busy_cnt_b1), 64'h1);
    nxt();
    idle(); wr(0, 3, 32'hAA);
    mid();
    chk("wb_byp_data", 64'(rd_data_b1[31:0]), 64'hAA);
    chk("wb_byp_busy", 64'(rd_busy_b1), 64'h0);
    chk("wb_nobyp_busy", 64'(rd_busy_b0), 64'h3);
    nxt(); idle();
    mid();
    chk("wb_cnt", 64'(busy_cnt_b1), 64'h0);
    nxt();
    idle(); wr(0, 3, 32'hBB); iss(3);
    nxt(); idle();
    mid();
    chk("isswr_busy", 64'(rd_busy_b1), 64'h3);
    chk("isswr_cnt", 64'(busy_cnt_b1), 64'h1);
    nxt();

    // x1, x2, x3 busy then reset during a write to x4
    idle(); iss(1); nxt();
    idle(); iss(2); nxt();
    idle(); iss(3); nxt();
    idle(); rd2(1, 4);
    mid();
    chk("three_cnt", 64'(busy_cnt_b1), 64'h3);
    nxt();
    idle(); rd2(1, 4); rst = 1'b1; wr(0, 4, 32'h55);
    nxt(); idle();
    mid();
    chk("mrst_cnt", 64'(busy_cnt_b1), 64'h0);
    chk("mrst_busy", 64'(rd_busy_b1), 64'h0);
    chk("mrst_x4", 64'(rd_data_b1[63:32]), 64'h0);
    chk("mrst_dbg", 64'(dbg_data_b1), 64'h0);
    nxt();

    // dbg_data shows stored value only
    idle(); wr(0, 4, 32'hCAFE);
    mid();
    chk("dbg_same", 64'(dbg_data_b1), 64'h0);
    nxt(); idle();
    mid();
    chk("dbg_next", 64'(dbg_data_b1), 64'hCAFE);
    nxt();

    // mixed traffic, checked by the model only
    for (int c = 0; c < 60; c++) begin
      idle();
      rd2(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) wr(0, AW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) wr(1, AW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 1) iss(AW'($urandom_range(0, 7)));
      if (c == 40) rst = 1'b1;
      nxt();
    end
    idle();
    nxt(); nxt();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
